// File: rtl/vga_pkg.sv
// vga_pkg
// Shared types and default timing for the raster timing generator.
//   vga_state_t  : scan controller states (IDLE / RUN / DRAIN)
//   vga_flags_t  : the per-pixel flag bundle that travels through the
//                  sync alignment stages (syncs, video enable, strobes)
//   VGA_*        : 640x480@60 timing, used as the generator defaults
package vga_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } vga_state_t;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic vidon;
      logic line_start;
      logic frame_start;
      logic vblank_start;
   } vga_flags_t;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt
// One raster axis (horizontal or vertical): a position counter laid out as
// active, front porch, sync, back porch, plus decode of the position the
// counter is about to take. The decode is of the *next* count so that the
// parent can register it alongside the counter and have both describe the
// same pixel on the same cycle.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   en           : pixel-clock enable; the counter only moves when high
//   adv          : advance by one (wrapping at TOTAL-1)
//   wrap_inh     : stop the scan on this axis: count parks at zero and all
//                  decoded flags read inactive
//   count        : current position (registered)
//   tc           : current position is TOTAL-1
//   sync_nxt     : sync level for the next position, polarity applied
//   active_nxt   : next position is in the visible region
//   start_nxt    : next position is 0
//   blank_nxt    : next position is the first blanking position (ACTIVE)
module vga_axis_cnt
   import vga_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter bit POL    = 1'b0,
   parameter int W      = 11
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         adv,
   input  logic         wrap_inh,
   output logic [W-1:0] count,
   output logic         tc,
   output logic         sync_nxt,
   output logic         active_nxt,
   output logic         start_nxt,
   output logic         blank_nxt
);

   localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
   localparam int SYNC_FIRST = ACTIVE + FP;
   localparam int SYNC_LAST  = ACTIVE + FP + SYNC - 1;

   if (TOTAL > (1 << W)) begin : g_width_check
      $error("vga_axis_cnt: W=%0d cannot hold TOTAL=%0d", W, TOTAL);
   end

   logic [W-1:0] count_d;

   // Next-position logic and its decode. Parking wins over advancing so the
   // end of a drained frame lands on zero with every flag inactive.
   always_comb begin
      tc         = (count == W'(TOTAL - 1));
      count_d    = count;
      sync_nxt   = ~POL;
      active_nxt = 1'b0;
      start_nxt  = 1'b0;
      blank_nxt  = 1'b0;
      if (wrap_inh) begin
         count_d = '0;
      end else if (adv) begin
         count_d = tc ? '0 : count + 1'b1;
      end
      if (!wrap_inh) begin
         if ((count_d >= W'(SYNC_FIRST)) && (count_d <= W'(SYNC_LAST))) begin
            sync_nxt = POL;
         end
         active_nxt = (count_d < W'(ACTIVE));
         start_nxt  = (count_d == '0);
         blank_nxt  = (count_d == W'(ACTIVE));
      end
   end

   // Position register; frozen whenever the pixel enable is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (en) begin
         count <= count_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised raster timing generator. A run/stop controller starts a scan
// on request and only stops it at the end of a complete frame. Pixel
// position (x, y) comes straight from the axis counters; the sync, video
// enable and event strobes can be delayed by SYNC_DLY enabled cycles to
// line up with a pipelined pixel path.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   pix_en        : pixel-clock enable; everything advances only when high
//   run           : level request, 1 = scan, 0 = stop at the next frame end
//   x, y          : current pixel position
//   hsync, vsync  : syncs, active level set by HS_POL / VS_POL
//   vidon         : visible region
//   line_start    : one enabled-cycle pulse at x==0 of every scanned line
//   frame_start   : one enabled-cycle pulse at (0,0)
//   vblank_start  : one enabled-cycle pulse at (0,V_ACTIVE)
//   busy          : scanning (RUN or DRAIN)
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int X_W      = 11,
   parameter int Y_W      = 10,
   parameter int SYNC_DLY = 0
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           pix_en,
   input  logic           run,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           hsync,
   output logic           vsync,
   output logic           vidon,
   output logic           line_start,
   output logic           frame_start,
   output logic           vblank_start,
   output logic           busy
);

   if ((SYNC_DLY < 0) || (SYNC_DLY > 4)) begin : g_dly_check
      $error("vga_timing_gen: SYNC_DLY=%0d outside 0..4", SYNC_DLY);
   end

   localparam vga_flags_t FLAGS_IDLE = '{hsync: ~HS_POL, vsync: ~VS_POL,
                                         vidon: 1'b0, line_start: 1'b0,
                                         frame_start: 1'b0, vblank_start: 1'b0};

   vga_state_t state;
   vga_state_t state_d;
   logic       adv_x;
   logic       adv_y;
   logic       park;
   logic       x_tc;
   logic       y_tc;
   logic       x_sync;
   logic       y_sync;
   logic       x_active;
   logic       y_active;
   logic       x_start;
   logic       y_start;
   logic       y_blank;
   logic       x_blank_unused;
   vga_flags_t flags_d;
   vga_flags_t pipe [0:SYNC_DLY];

   // Scan controller. Leaving IDLE does not advance the counters, so the
   // first scanning cycle presents (0,0). A drain that reaches the last
   // pixel of the frame parks both axes instead of wrapping, which also
   // suppresses the frame_start that a wrap would otherwise produce.
   always_comb begin
      state_d = state;
      if (pix_en) begin
         case (state)
            IDLE:    if (run) state_d = RUN;
            RUN:     if (!run) state_d = DRAIN;
            DRAIN: begin
               if (run) begin
                  state_d = RUN;
               end else if (x_tc && y_tc) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      adv_x = (state != IDLE);
      adv_y = adv_x && x_tc;
      park  = (state_d == IDLE);
   end

   // Controller state and the registered busy flag, both tracking the
   // state the block is entering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else if (pix_en) begin
         state <= state_d;
         busy  <= (state_d != IDLE);
      end
   end

   vga_axis_cnt #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HS_POL),
      .W      (X_W)
   ) u_h_axis (
      .clk        (clk),
      .reset      (reset),
      .en         (pix_en),
      .adv        (adv_x),
      .wrap_inh   (park),
      .count      (x),
      .tc         (x_tc),
      .sync_nxt   (x_sync),
      .active_nxt (x_active),
      .start_nxt  (x_start),
      .blank_nxt  (x_blank_unused)
   );

   vga_axis_cnt #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VS_POL),
      .W      (Y_W)
   ) u_v_axis (
      .clk        (clk),
      .reset      (reset),
      .en         (pix_en),
      .adv        (adv_y),
      .wrap_inh   (park),
      .count      (y),
      .tc         (y_tc),
      .sync_nxt   (y_sync),
      .active_nxt (y_active),
      .start_nxt  (y_start),
      .blank_nxt  (y_blank)
   );

   // Flags for the pixel the counters are about to present. The axis
   // decode already reads inactive when parking, so IDLE emits nothing.
   // Every strobe is qualified by x reaching 0, which makes frame and
   // vblank strobes single-pixel events rather than whole-line levels.
   always_comb begin
      flags_d              = FLAGS_IDLE;
      flags_d.hsync        = x_sync;
      flags_d.vsync        = y_sync;
      flags_d.vidon        = x_active & y_active;
      flags_d.line_start   = x_start;
      flags_d.frame_start  = x_start & y_start;
      flags_d.vblank_start = x_start & y_blank;
   end

   // Alignment stages. Stage 0 lines up with x/y; each further stage lags
   // one enabled cycle, so the last stage describes the pixel shown
   // SYNC_DLY enabled cycles earlier. Holding on pix_en=0 keeps strobes
   // one enabled cycle wide however slow the pixel clock is.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= SYNC_DLY; i++) begin
            pipe[i] <= FLAGS_IDLE;
         end
      end else if (pix_en) begin
         pipe[0] <= flags_d;
         for (int i = 1; i <= SYNC_DLY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign hsync        = pipe[SYNC_DLY].hsync;
   assign vsync        = pipe[SYNC_DLY].vsync;
   assign vidon        = pipe[SYNC_DLY].vidon;
   assign line_start   = pipe[SYNC_DLY].line_start;
   assign frame_start  = pipe[SYNC_DLY].frame_start;
   assign vblank_start = pipe[SYNC_DLY].vblank_start;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator that replaces the fixed 640x480 sync block. It produces pixel coordinates, hsync/vsync, video-enable and frame/line event strobes. Porch and sync widths, sync polarity, pixel-clock enable and an output alignment delay are all configurable. A run/stop FSM starts and stops scanning only on frame boundaries, so the display never receives a truncated frame. It sits between the clock/reset logic and the pixel renderer/DAC driver.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
X_W, 11, x counter width; must satisfy 2^X_W >= H_TOTAL
Y_W, 10, y counter width; must satisfy 2^Y_W >= V_TOTAL
SYNC_DLY, 0, pix_en-qualified delay stages (0..4) applied to hsync/vsync/vidon/strobes relative to x/y

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pix_en  in  1  pixel-clock enable; all counting and delay stages advance only when high
run  in  1  level request: 1 = scan frames, 0 = stop at the next frame end
x  out  X_W  current horizontal position
y  out  Y_W  current vertical position
hsync  out  1  horizontal sync, polarity set by HS_POL
vsync  out  1  vertical sync, polarity set by VS_POL
vidon  out  1  high inside the visible region
line_start  out  1  one pix_en-cycle pulse at x==0 of every line while scanning
frame_start  out  1  one pix_en-cycle pulse at x==0, y==0
vblank_start  out  1  one pix_en-cycle pulse at x==0, y==V_ACTIVE
busy  out  1  high in RUN and DRAIN

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line region order is active, FP, sync, BP.
- hsync is asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync is asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]; vidon = x<H_ACTIVE && y<V_ACTIVE.
- All outputs are registered. At SYNC_DLY=0, hsync/vsync/vidon/strobes describe the same pixel as the x/y on the same cycle. At SYNC_DLY=N, they describe the pixel shown N pix_en cycles earlier; x/y are not delayed.
- Reset values: x=0, y=0, hsync=~HS_POL, vsync=~VS_POL, vidon=0, all strobes 0, busy=0, FSM=IDLE, delay stages loaded with inactive values.
- FSM states: IDLE, RUN, DRAIN. All transitions are evaluated on pix_en cycles only.
  - IDLE: counters hold at (0,0); syncs inactive; vidon 0; no strobes. run=1 -> RUN. The first RUN cycle presents (0,0) with frame_start=1 and line_start=1.
  - RUN: x increments each pix_en cycle. x==H_TOTAL-1 -> x=0, y+1. At (H_TOTAL-1, V_TOTAL-1) both counters wrap to 0. Seeing run=0 -> DRAIN.
  - DRAIN: identical to RUN, but at (H_TOTAL-1, V_TOTAL-1) the block goes to IDLE instead of wrapping, with no frame_start. If run=1 is seen again in DRAIN -> RUN with no discontinuity.
- pix_en=0: every register holds its value; strobes hold their value, so a strobe is high for exactly one pix_en-qualified cycle.
- Asynchronous reset mid-frame: all state returns to reset values immediately; no partial-frame recovery.
- No counter ever exceeds TOTAL-1; the width checks are elaboration-time assertions.

Decomposition:
- Package vga_pkg: fsm state enum (IDLE/RUN/DRAIN) and the default 640x480@60 timing constants; the 800x600 set is added later.
- Sub-module vga_axis_cnt (parametrised by ACTIVE/FP/SYNC/BP/POL/W), instantiated twice for the horizontal and vertical axes. Inputs are an advance enable and a wrap-inhibit; outputs are count, terminal-count, sync, active and region-start flags.
- The top level holds the FSM, strobe generation and the SYNC_DLY shift stages.

Test Plan:
- Default params, pix_en=1, run=1 from reset -> frame_start at (0,0). hsync low exactly for x 656..751; vsync low exactly for y 490..491. Next frame_start comes 420000 cycles later.
- pix_en toggling 1-in-4 -> all waveforms are the stretched equivalent. Strobes stay high for 4 clk cycles, i.e. one enabled cycle, and x advances once per enable.
- run dropped at y=100 -> frame completes to (799,524), then IDLE with (0,0), busy=0, syncs inactive. run re-raised during DRAIN at y=300 -> scanning continues with no gap.
- HS_POL=1, VS_POL=1, SYNC_DLY=2 -> syncs are active-high, and hsync rises when x==658 is presented.
- Small mode (H 8/1/2/1, V 4/1/1/1) -> x wraps at 11, y wraps at 6. vblank_start fires at y==4, and vidon is high for exactly 32 pixels per frame.
- Asynchronous reset asserted mid-line, between clock edges -> outputs reach reset values before the next clk edge. After release, the block stays IDLE until run is set.
